// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: state/mode encodings and the seconds limit shared by the stopwatch core
package stopwatch_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} sw_state_e;
  typedef enum logic {UP, DOWN} sw_mode_e;
  localparam int SEC_MAX = 59;
endpackage

// File: rtl/lap_fifo.sv
// lap_fifo: first-word-fall-through FIFO that accepts a push while full when a pop happens in the same cycle
module lap_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic do_push, do_pop;
  always_comb begin
    empty = wp == rp;
    full = wp == {~rp[AW], rp[AW-1:0]};
    do_pop = pop && !empty;
    do_push = push && (!full || do_pop);
    dout = empty ? '0 : mem[rp[AW-1:0]];
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wp <= '0;
      rp <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) mem[wp[AW-1:0]] <= din;
      wp <= do_push ? wp + (AW+1)'(1) : wp;
      rp <= do_pop ? rp + (AW+1)'(1) : rp;
    end
endmodule

// File: rtl/lap_stopwatch.sv
// lap_stopwatch: MM:SS up/down stopwatch with run-gated prescaler, countdown expiry, minute rollover and lap FIFO
module lap_stopwatch
  import stopwatch_pkg::*;
#(
  parameter int CLK_DIV = 50_000_000,
  parameter int MAX_MIN = 59,
  parameter int LAP_DEPTH = 4,
  localparam int MM_W = $clog2(MAX_MIN + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            stop,
  input  logic            clear,
  input  logic            mode,
  input  logic            load_en,
  input  logic [MM_W-1:0] load_mm,
  input  logic [5:0]      load_ss,
  input  logic            lap,
  input  logic            lap_rd,
  output logic [MM_W-1:0] MM,
  output logic [5:0]      SS,
  output logic            running,
  output logic            tick,
  output logic            rollover,
  output logic            expired,
  output logic            done,
  output logic            lap_valid,
  output logic [MM_W-1:0] lap_mm,
  output logic [5:0]      lap_ss,
  output logic            lap_ovf
);
  localparam int PW = $clog2(CLK_DIV);
  localparam logic [MM_W-1:0] MM_MAX = MM_W'(MAX_MIN);
  localparam logic [5:0] SS_MAX = 6'(SEC_MAX);
  sw_state_e state, state_n;
  sw_mode_e mode_q;
  logic [PW-1:0] pre, pre_n;
  logic [MM_W-1:0] mm_n;
  logic [5:0] ss_n;
  logic [MM_W+5:0] head;
  logic down, go, hit_zero, wrap, lap_push, full, empty;
  assign running = state == RUN;
  assign done = state == DONE;
  assign lap_valid = !empty;
  assign {lap_mm, lap_ss} = head;
  always_comb begin
    tick = state == RUN && pre == PW'(CLK_DIV - 1);
    down = state == IDLE ? mode : mode_q == DOWN;
    go = start && !stop && !(down && MM == '0 && SS == '0);
    hit_zero = tick && mode_q == DOWN && MM == '0 && SS == 6'd1;
    wrap = tick && mode_q == UP && MM == MM_MAX && SS == SS_MAX;
    lap_push = lap && (state == RUN || state == PAUSE);
    state_n = clear ? IDLE
            : state == RUN ? (hit_zero ? DONE : stop ? PAUSE : RUN)
            : (state == IDLE || state == PAUSE) && go ? RUN : state;
    pre_n = clear || state == IDLE ? '0 : state != RUN ? pre : tick ? '0 : pre + PW'(1);
    mm_n = MM;
    ss_n = SS;
    if (clear) begin
      mm_n = '0;
      ss_n = '0;
    end else if (state == IDLE && load_en) begin
      mm_n = load_mm > MM_MAX ? MM_MAX : load_mm;
      ss_n = load_ss > SS_MAX ? SS_MAX : load_ss;
    end else if (tick && mode_q == DOWN) begin
      ss_n = SS == '0 ? SS_MAX : SS - 6'd1;
      mm_n = SS == '0 ? MM - MM_W'(1) : MM;
    end else if (tick) begin
      ss_n = SS == SS_MAX ? '0 : SS + 6'd1;
      mm_n = SS != SS_MAX ? MM : MM == MM_MAX ? '0 : MM + MM_W'(1);
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      mode_q <= UP;
      pre <= '0;
      MM <= '0;
      SS <= '0;
      rollover <= 1'b0;
      expired <= 1'b0;
      lap_ovf <= 1'b0;
    end else begin
      state <= state_n;
      mode_q <= state == IDLE ? sw_mode_e'(mode) : mode_q;
      pre <= pre_n;
      MM <= mm_n;
      SS <= ss_n;
      rollover <= !clear && wrap;
      expired <= !clear && hit_zero;
      lap_ovf <= !clear && (lap_ovf || (lap_push && full && !lap_rd));
    end
  lap_fifo #(.WIDTH(MM_W + 6), .DEPTH(LAP_DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .clr(clear),
    .push(lap_push),
    .pop(lap_rd),
    .din({MM, SS}),
    .dout(head),
    .empty(empty),
    .full(full)
  );
endmodule

// File: tb/tb_lap_stopwatch.sv
// tb_lap_stopwatch: scoreboard bench comparing lap_stopwatch against a seconds-based reference model
module tb_lap_stopwatch;
  localparam int CLK_DIV = 5;
  localparam int MAX_MIN = 59;
  localparam int LAP_DEPTH = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
  typedef struct {
    int mm, ss, run, tk, roll, ex, dn, lv, lmm, lss, ovf;
  } exp_t;
  logic clk = 1'b0, reset = 1'b1;
  logic start = 1'b0, stop = 1'b0, clear = 1'b0, mode = 1'b0, load_en = 1'b0, lap = 1'b0, lap_rd = 1'b0;
  logic [5:0] load_mm = '0, load_ss = '0;
  logic [5:0] mm_o, ss_o, lap_mm_o, lap_ss_o;
  logic running_o, tick_o, rollover_o, expired_o, done_o, lap_valid_o, lap_ovf_o;
  int n_chk = 0, n_err = 0, n_tick = 0, n_roll = 0, n_exp = 0;
  int m_st, m_t, m_fr, m_roll, m_exp, m_ovf;
  bit m_md;
  int m_lq[$];
  exp_t exp_q[$];
  always #5 clk = ~clk;
  lap_stopwatch #(.CLK_DIV(CLK_DIV), .MAX_MIN(MAX_MIN), .LAP_DEPTH(LAP_DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear), .mode(mode),
    .load_en(load_en), .load_mm(load_mm), .load_ss(load_ss), .lap(lap), .lap_rd(lap_rd),
    .MM(mm_o), .SS(ss_o), .running(running_o), .tick(tick_o), .rollover(rollover_o),
    .expired(expired_o), .done(done_o), .lap_valid(lap_valid_o), .lap_mm(lap_mm_o),
    .lap_ss(lap_ss_o), .lap_ovf(lap_ovf_o)
  );
  function automatic void chk(string nm, int act, int req);
    n_chk++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, req, $time);
    end
  endfunction
  function automatic void model_reset();
    m_st = M_IDLE; m_t = 0; m_fr = 0; m_roll = 0; m_exp = 0; m_ovf = 0; m_md = 0;
    m_lq.delete();
  endfunction
  function automatic void model_step();
    int t0 = m_t;
    bit tk = m_st == M_RUN && m_fr == CLK_DIV - 1;
    bit dn = m_st == M_IDLE ? mode : m_md;
    bit can_go = start && !stop && !(dn && t0 == 0);
    if (m_st == M_IDLE) m_md = mode;
    m_roll = 0;
    m_exp = 0;
    if (clear) begin
      m_st = M_IDLE; m_t = 0; m_fr = 0; m_ovf = 0;
      m_lq.delete();
      return;
    end
    if (lap_rd && m_lq.size() > 0) void'(m_lq.pop_front());
    if (lap && (m_st == M_RUN || m_st == M_PAUSE)) begin
      if (m_lq.size() < LAP_DEPTH) m_lq.push_back(t0);
      else m_ovf = 1;
    end
    case (m_st)
      M_IDLE: begin
        m_fr = 0;
        if (load_en) m_t = (load_mm > MAX_MIN ? MAX_MIN : int'(load_mm)) * 60 + (load_ss > 59 ? 59 : int'(load_ss));
        if (can_go) m_st = M_RUN;
      end
      M_PAUSE: if (can_go) m_st = M_RUN;
      M_RUN: begin
        m_fr = (m_fr + 1) % CLK_DIV;
        if (tk && m_md) begin
          m_t--;
          if (m_t == 0) m_exp = 1;
        end else if (tk) begin
          m_t++;
          if (m_t == (MAX_MIN + 1) * 60) begin
            m_t = 0;
            m_roll = 1;
          end
        end
        m_st = m_exp ? M_DONE : stop ? M_PAUSE : M_RUN;
      end
      default: ;
    endcase
  endfunction
  function automatic exp_t snap();
    exp_t e;
    e.mm = m_t / 60; e.ss = m_t % 60;
    e.run = int'(m_st == M_RUN);
    e.tk = int'(m_st == M_RUN && m_fr == CLK_DIV - 1);
    e.roll = m_roll; e.ex = m_exp; e.dn = int'(m_st == M_DONE);
    e.lv = int'(m_lq.size() > 0);
    e.lmm = m_lq.size() > 0 ? m_lq[0] / 60 : 0;
    e.lss = m_lq.size() > 0 ? m_lq[0] % 60 : 0;
    e.ovf = m_ovf;
    return e;
  endfunction
  task automatic cyc();
    model_step();
    exp_q.push_back(snap());
    @(negedge clk);
    {start, stop, clear, load_en, lap, lap_rd} = '0;
  endtask
  initial forever begin
    exp_t e;
    @(posedge clk);
    #1;
    if (tick_o) n_tick++;
    if (rollover_o) n_roll++;
    if (expired_o) n_exp++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("MM", int'(mm_o), e.mm);
      chk("SS", int'(ss_o), e.ss);
      chk("running", int'(running_o), e.run);
      chk("tick", int'(tick_o), e.tk);
      chk("rollover", int'(rollover_o), e.roll);
      chk("expired", int'(expired_o), e.ex);
      chk("done", int'(done_o), e.dn);
      chk("lap_valid", int'(lap_valid_o), e.lv);
      chk("lap_mm", int'(lap_mm_o), e.lmm);
      chk("lap_ss", int'(lap_ss_o), e.lss);
      chk("lap_ovf", int'(lap_ovf_o), e.ovf);
    end
  end
  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_MM", int'(mm_o), 0);
    chk("rst_SS", int'(ss_o), 0);
    chk("rst_running", int'(running_o), 0);
    chk("rst_done", int'(done_o), 0);
    chk("rst_lap_valid", int'(lap_valid_o), 0);
    chk("rst_lap_ovf", int'(lap_ovf_o), 0);
    reset = 1'b0;
    n_tick = 0;
    start = 1'b1;
    cyc();
    repeat (300) cyc();
    chk("run300_MM", int'(mm_o), 1);
    chk("run300_SS", int'(ss_o), 0);
    chk("run300_ticks", n_tick, 60);
    chk("run300_running", int'(running_o), 1);
    repeat (2) cyc();
    stop = 1'b1;
    cyc();
    repeat (100) cyc();
    start = 1'b1;
    cyc();
    repeat (12) cyc();
    clear = 1'b1;
    cyc();
    load_en = 1'b1; load_mm = 6'd63; load_ss = 6'd63;
    cyc();
    chk("clamp_MM", int'(mm_o), 59);
    chk("clamp_SS", int'(ss_o), 59);
    n_roll = 0;
    start = 1'b1;
    cyc();
    repeat (20) cyc();
    chk("roll_count", n_roll, 1);
    chk("roll_MM", int'(mm_o), 0);
    chk("roll_SS", int'(ss_o), 3);
    chk("roll_running", int'(running_o), 1);
    clear = 1'b1;
    cyc();
    mode = 1'b1;
    start = 1'b1;
    cyc();
    chk("down_zero_start", int'(running_o), 0);
    load_en = 1'b1; load_mm = 6'd0; load_ss = 6'd3;
    cyc();
    n_exp = 0;
    start = 1'b1;
    cyc();
    repeat (20) cyc();
    chk("cd_done", int'(done_o), 1);
    chk("cd_SS", int'(ss_o), 0);
    chk("cd_expired", n_exp, 1);
    start = 1'b1;
    cyc();
    repeat (5) cyc();
    chk("cd_done_hold", int'(done_o), 1);
    clear = 1'b1;
    cyc();
    chk("cd_clear", int'(done_o), 0);
    mode = 1'b0;
    cyc();
    start = 1'b1;
    cyc();
    for (int k = 1; k <= 5; k++) begin
      for (int g = 0; g < 20 && m_t != k; g++) cyc();
      lap = 1'b1;
      cyc();
    end
    stop = 1'b1;
    cyc();
    chk("lap_ovf", int'(lap_ovf_o), 1);
    for (int k = 1; k <= 4; k++) begin
      chk("lap_head_ss", int'(lap_ss_o), k);
      chk("lap_head_valid", int'(lap_valid_o), 1);
      lap_rd = 1'b1;
      cyc();
    end
    chk("lap_empty", int'(lap_valid_o), 0);
    clear = 1'b1;
    cyc();
    start = 1'b1;
    cyc();
    repeat (12) cyc();
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("async_SS", int'(ss_o), 0);
    chk("async_MM", int'(mm_o), 0);
    chk("async_running", int'(running_o), 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    start = 1'b1;
    cyc();
    repeat (3) cyc();
    start = 1'b1;
    stop = 1'b1;
    cyc();
    chk("start_stop_pause", int'(running_o), 0);
    repeat (3) cyc();
    for (int n = 0; n < 3000; n++) begin
      start = $urandom_range(0, 7) == 0;
      stop = $urandom_range(0, 15) == 0;
      clear = $urandom_range(0, 63) == 0;
      mode = 1'($urandom_range(0, 1));
      load_en = $urandom_range(0, 7) == 0;
      load_mm = 6'($urandom_range(0, 63));
      load_ss = 6'($urandom_range(0, 63));
      lap = $urandom_range(0, 7) == 0;
      lap_rd = $urandom_range(0, 5) == 0;
      cyc();
    end
    @(posedge clk);
    #2;
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
